// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB writeback register with FANOUT identical copies, retired-write history, forwarding lookup and retire counter.
// One-cycle latency from MEM to the copies. Hold freezes all state, Bubb inserts a null writeback.
`ifndef MEM_WB_STALL_DEFS
`define MEM_WB_STALL_DEFS
`define StallBus 1:0
`define Pass 2'b00
`define Hold 2'b01
`define Bubb 2'b10
`endif

module mem_wb_pipe_reg #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FANOUT     = 2,
  parameter int HIST_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [`StallBus]                 stall,
  input  logic [ADDR_W-1:0]                rd_addr_i,
  input  logic                             rd_write_i,
  input  logic [DATA_W-1:0]                rd_data_i,
  input  logic                             hist_clr_i,
  input  logic [ADDR_W-1:0]                fwd_addr_i,
  output logic [FANOUT*ADDR_W-1:0]         rd_addr_o,
  output logic [FANOUT-1:0]                rd_write_o,
  output logic [FANOUT*DATA_W-1:0]         rd_data_o,
  output logic                             fwd_hit_o,
  output logic [DATA_W-1:0]                fwd_data_o,
  output logic [$clog2(HIST_DEPTH):0]      hist_cnt_o,
  output logic [CNT_W-1:0]                 retire_cnt_o
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int HC_W  = PTR_W + 1;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } hist_t;

  hist_t             hist [HIST_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [HC_W-1:0]   hist_cnt;
  logic [CNT_W-1:0]  retire_cnt;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_we;
  logic [DATA_W-1:0] wb_dat;
  logic              eff_we;
  logic              push;
  logic [PTR_W-1:0]  idx;

  assign eff_we = rd_write_i && (rd_addr_i != '0);
  assign push   = (stall == `Pass) && eff_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_addr    <= '0;
      wb_we      <= 1'b0;
      wb_dat     <= '0;
      wptr       <= '0;
      hist_cnt   <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i].vld <= 1'b0;
    end else begin
      case (stall)
        `Pass: begin
          wb_addr <= rd_addr_i;
          wb_we   <= eff_we;
          wb_dat  <= rd_data_i;
        end
        `Bubb: begin
          wb_addr <= '0;
          wb_we   <= 1'b0;
          wb_dat  <= '0;
        end
        default: ;
      endcase

      if (push) retire_cnt <= retire_cnt + 1'b1;

      // A clear wins over a same-cycle push; the retire count still advances.
      if (hist_clr_i) begin
        wptr     <= '0;
        hist_cnt <= '0;
        for (int i = 0; i < HIST_DEPTH; i++) hist[i].vld <= 1'b0;
      end else if (push) begin
        hist[wptr] <= '{vld: 1'b1, addr: rd_addr_i, dat: rd_data_i};
        wptr       <= wptr + 1'b1;
        if (hist_cnt != HC_W'(HIST_DEPTH)) hist_cnt <= hist_cnt + 1'b1;
      end
    end
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    idx        = '0;
    for (int a = HIST_DEPTH; a >= 1; a--) begin
      idx = wptr - PTR_W'(a);
      if (hist[idx].vld && (hist[idx].addr == fwd_addr_i) && (fwd_addr_i != '0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = hist[idx].dat;
      end
    end
  end

  for (genvar k = 0; k < FANOUT; k++) begin : g_copy
    assign rd_addr_o[k*ADDR_W +: ADDR_W] = wb_addr;
    assign rd_data_o[k*DATA_W +: DATA_W] = wb_dat;
    assign rd_write_o[k]                 = wb_we;
  end

  assign hist_cnt_o   = hist_cnt;
  assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed plus randomized checks of mem_wb_pipe_reg against a queue-based reference model.
`ifndef MEM_WB_STALL_DEFS
`define MEM_WB_STALL_DEFS
`define StallBus 1:0
`define Pass 2'b00
`define Hold 2'b01
`define Bubb 2'b10
`endif

module tb_mem_wb_pipe_reg;
  localparam int AW = 5, DW = 32, FO = 3, HD = 4, CW = 4;
  localparam int HCW = $clog2(HD) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        stall;
  logic [AW-1:0]     rd_addr_i;
  logic              rd_write_i;
  logic [DW-1:0]     rd_data_i;
  logic              hist_clr_i;
  logic [AW-1:0]     fwd_addr_i;
  logic [FO*AW-1:0]  rd_addr_o;
  logic [FO-1:0]     rd_write_o;
  logic [FO*DW-1:0]  rd_data_o;
  logic              fwd_hit_o;
  logic [DW-1:0]     fwd_data_o;
  logic [HCW-1:0]    hist_cnt_o;
  logic [CW-1:0]     retire_cnt_o;

  mem_wb_pipe_reg #(.ADDR_W(AW), .DATA_W(DW), .FANOUT(FO), .HIST_DEPTH(HD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rd_addr_i(rd_addr_i), .rd_write_i(rd_write_i), .rd_data_i(rd_data_i),
    .hist_clr_i(hist_clr_i), .fwd_addr_i(fwd_addr_i),
    .rd_addr_o(rd_addr_o), .rd_write_o(rd_write_o), .rd_data_o(rd_data_o),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .hist_cnt_o(hist_cnt_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            m_ret;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_dat;
  int            vecs = 0;
  int            errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference model on the same edge, then sample away from it.
  task automatic apply(input logic [1:0] st, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d, input logic clr, input logic r);
    logic eff;
    stall = st; rd_addr_i = a; rd_write_i = w; rd_data_i = d; hist_clr_i = clr; rst = r;
    @(posedge clk);
    eff = w && (a != 0);
    if (r) begin
      q.delete(); m_ret = 0; m_addr = 0; m_we = 0; m_dat = 0;
    end else begin
      if (st == `Pass) begin
        m_addr = a; m_we = eff; m_dat = d;
        if (eff) begin
          m_ret = (m_ret + 1) % (1 << CW);
          if (!clr) begin
            q.push_back('{a: a, d: d});
            if (q.size() > HD) void'(q.pop_front());
          end
        end
      end else if (st == `Bubb) begin
        m_addr = 0; m_we = 0; m_dat = 0;
      end
      if (clr) q.delete();
    end
    #1;
  endtask

  task automatic check_outs();
    for (int k = 0; k < FO; k++) begin
      chk($sformatf("addr[%0d]", k), 64'(rd_addr_o[k*AW +: AW]), 64'(m_addr));
      chk($sformatf("we[%0d]", k), 64'(rd_write_o[k]), 64'(m_we));
      chk($sformatf("data[%0d]", k), 64'(rd_data_o[k*DW +: DW]), 64'(m_dat));
    end
    chk("hist_cnt", 64'(hist_cnt_o), 64'(q.size()));
    chk("retire_cnt", 64'(retire_cnt_o), 64'(m_ret));
  endtask

  task automatic check_fwd(input logic [AW-1:0] fa);
    logic          hit;
    logic [DW-1:0] dat;
    fwd_addr_i = fa;
    #1;
    hit = 0; dat = 0;
    if (fa != 0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a == fa) begin hit = 1; dat = q[i].d; break; end
    chk($sformatf("fwd_hit x%0d", fa), 64'(fwd_hit_o), 64'(hit));
    chk($sformatf("fwd_data x%0d", fa), 64'(fwd_data_o), 64'(dat));
  endtask

  initial begin
    fwd_addr_i = 0;
    m_ret = 0; m_addr = 0; m_we = 0; m_dat = 0;

    // 1: reset then hold
    apply(`Hold, 0, 0, 0, 0, 1);
    apply(`Hold, 0, 0, 0, 0, 1);
    apply(`Hold, 0, 0, 0, 0, 0);
    check_outs();
    chk("reset hist_cnt", 64'(hist_cnt_o), 64'd0);
    check_fwd(5);

    // 2: single write, hold, bubble
    apply(`Pass, 5, 1, 32'hDEADBEEF, 0, 0);
    check_outs();
    chk("t2 data", 64'(rd_data_o[DW-1:0]), 64'hDEADBEEF);
    chk("t2 retire", 64'(retire_cnt_o), 64'd1);
    check_fwd(5);
    chk("t2 fwd", 64'(fwd_data_o), 64'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      apply(`Hold, 9, 1, 32'h5555, 0, 0);
      check_outs();
    end
    apply(`Bubb, 9, 1, 32'h5555, 0, 0);
    check_outs();
    check_fwd(5);
    chk("t2 bubb hit", 64'(fwd_hit_o), 64'd1);

    // 3: x0 write is suppressed
    apply(`Pass, 0, 1, 32'h1234, 0, 0);
    check_outs();
    chk("t3 we", 64'(rd_write_o), 64'd0);

    // 4: history overflow and youngest-wins
    for (int r = 1; r <= 6; r++) begin
      apply(`Pass, AW'(r), 1, DW'(r * 16), 0, 0);
      check_outs();
    end
    chk("t4 hist_cnt", 64'(hist_cnt_o), 64'd4);
    for (int r = 0; r <= 7; r++) check_fwd(AW'(r));
    apply(`Pass, 3, 1, 32'h99, 0, 0);
    check_fwd(3);
    chk("t4 youngest", 64'(fwd_data_o), 64'h99);

    // 5: push dropped by same-cycle clear
    apply(`Pass, 7, 1, 32'h77, 1, 0);
    check_outs();
    chk("t5 hist_cnt", 64'(hist_cnt_o), 64'd0);
    check_fwd(7);

    // 6: counter wrap, then reset during Pass
    while (m_ret != (1 << CW) - 1) apply(`Pass, 2, 1, 32'hA, 0, 0);
    check_outs();
    apply(`Pass, 4, 1, 32'hB, 0, 0);
    chk("t6 wrap", 64'(retire_cnt_o), 64'd0);
    check_outs();
    apply(`Pass, 6, 1, 32'hC, 0, 1);
    check_outs();
    check_fwd(4);

    // Randomized traffic, including the undefined stall code.
    for (int n = 0; n < 300; n++) begin
      apply(2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom, ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
      check_outs();
      check_fwd(AW'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
